// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO: fixed-latency multiply, restoring radix-2 divide.
// Optional MULDIV_DIV_EARLY_OUT_EN: skip the divide loop when |a| < |b|.
module muldiv_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid_i,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MUL_WAIT = 3'd1;
    localparam logic [2:0] S_DIV_RUN  = 3'd2;
    localparam logic [2:0] S_DIV_FIX  = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_prod;
    logic [31:0]      r_quo;
    logic [31:0]      r_rem;
    logic [31:0]      r_div;
    logic             r_qsign;
    logic             r_rsign;
    logic             r_dz;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic        w_accept;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_signed;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_shift;
    logic [32:0] w_sub;
    logic        w_ge;

    assign w_accept = (r_state == S_IDLE) && req_valid_i && !flush_i;
    assign w_is_mul = (req_op_i == OP_MULT) || (req_op_i == OP_MULTU);
    assign w_is_div = (req_op_i == OP_DIV)  || (req_op_i == OP_DIVU);
    assign w_signed = (req_op_i == OP_MULT) || (req_op_i == OP_DIV);

    // Sign-extending only for signed ops lets one 64-bit multiplier serve both flavours.
    assign w_a_ext = {{32{w_signed & req_a_i[31]}}, req_a_i};
    assign w_b_ext = {{32{w_signed & req_b_i[31]}}, req_b_i};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_a_mag = (w_signed && req_a_i[31]) ? -req_a_i : req_a_i;
    assign w_b_mag = (w_signed && req_b_i[31]) ? -req_b_i : req_b_i;

    // Partial remainder stays below the divisor, so the restored value fits in 32 bits.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_sub   = w_shift - {1'b0, r_div};
    assign w_ge    = (w_shift >= {1'b0, r_div});

    assign stall_o = rstn && (
                     (w_accept && (w_is_mul || w_is_div)) ||
                     (((r_state == S_MUL_WAIT) || (r_state == S_DIV_RUN) ||
                       (r_state == S_DIV_FIX)) && !flush_i));
    assign busy_o  = (r_state != S_IDLE);
    assign done_o  = (r_state == S_DONE);
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (req_op_i == OP_MTHI) begin
                            r_hi <= req_a_i;
                        end else if (req_op_i == OP_MTLO) begin
                            r_lo <= req_a_i;
                        end else if (w_is_mul) begin
                            r_prod  <= w_prod;
                            r_cnt   <= CNT_W'(MUL_LAT - 1);
                            r_state <= S_MUL_WAIT;
                        end else if (w_is_div) begin
                            r_quo   <= w_a_mag;
                            r_rem   <= '0;
                            r_div   <= w_b_mag;
                            r_qsign <= w_signed & (req_a_i[31] ^ req_b_i[31]);
                            r_rsign <= w_signed & req_a_i[31];
                            r_dz    <= (req_b_i == 32'd0);
                            r_cnt   <= CNT_W'(31);
                            if (req_b_i == 32'd0) begin
                                r_state <= S_DIV_FIX;
`ifdef MULDIV_DIV_EARLY_OUT_EN
                            end else if (w_a_mag < w_b_mag) begin
                                r_quo   <= '0;
                                r_rem   <= w_a_mag;
                                r_state <= S_DIV_FIX;
`endif
                            end else begin
                                r_state <= S_DIV_RUN;
                            end
                        end
                    end
                end
                S_MUL_WAIT: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == '0) begin
                        r_hi    <= r_prod[63:32];
                        r_lo    <= r_prod[31:0];
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DIV_RUN: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_ge ? w_sub[31:0] : w_shift[31:0];
                        r_quo <= {r_quo[30:0], w_ge};
                        if (r_cnt == '0) begin
                            r_state <= S_DIV_FIX;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                S_DIV_FIX: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (r_dz) begin
                            r_hi <= '0;
                            r_lo <= '0;
                        end else begin
                            r_lo <= r_qsign ? -r_quo : r_quo;
                            r_hi <= r_rsign ? -r_rem : r_rem;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (MUL_LAT=4); expectations are hand-computed.
module tb_muldiv_ctrl;

    logic        clk;
    logic        rstn;
    logic        req_valid_i;
    logic [2:0]  req_op_i;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int total = 0;
    int bad   = 0;
    int done_total = 0;
    int ns;
    int nd;
    int d0;
`ifdef MULDIV_DIV_EARLY_OUT_EN
    int exp_early_stall = 2;
`else
    int exp_early_stall = 34;
`endif

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    muldiv_ctrl #(.MUL_LAT(4), .CNT_W(6)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid_i (req_valid_i),
        .req_op_i    (req_op_i),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstn && done_o) done_total++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds the request until the cycle after done (EX advances on the DONE edge); bounded at 60 cycles.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n_stall, output int n_done);
        int  k;
        bit  fin;
        n_stall = 0;
        n_done  = 0;
        k       = 0;
        fin     = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_a_i     = a;
        req_b_i     = b;
        while (!fin && k < 60) begin
            #1;
            if (stall_o) n_stall++;
            if (done_o) begin
                n_done++;
                fin = 1'b1;
            end else if (k > 0 && !stall_o && !busy_o) begin
                fin = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        req_valid_i = 1'b0;
        req_op_i    = 3'b000;
    endtask

    initial begin
        rstn        = 1'b0;
        req_valid_i = 1'b0;
        req_op_i    = 3'b000;
        req_a_i     = '0;
        req_b_i     = '0;
        flush_i     = 1'b0;

        // Reset: stall must stay low even with a multiply presented.
        @(negedge clk);
        req_valid_i = 1'b1;
        req_op_i    = OP_MULT;
        #1;
        check("stall_in_reset", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        req_valid_i = 1'b0;
        req_op_i    = 3'b000;
        #1;
        check("reset_hi", {32'd0, hi_o}, 64'd0);
        check("reset_lo", {32'd0, lo_o}, 64'd0);
        check("reset_busy", {63'd0, busy_o}, 64'd0);
        check("reset_done", {63'd0, done_o}, 64'd0);
        rstn = 1'b1;

        do_op(OP_MTHI, 32'h12345678, 32'd0, ns, nd);
        check("mthi_stall", 64'(ns), 64'd0);
        check("mthi_hi", {32'd0, hi_o}, 64'h12345678);
        do_op(OP_MTLO, 32'h9ABCDEF0, 32'd0, ns, nd);
        check("mtlo_stall", 64'(ns), 64'd0);
        check("mtlo_lo", {32'd0, lo_o}, 64'h9ABCDEF0);
        check("mtlo_hi_kept", {32'd0, hi_o}, 64'h12345678);
        check("mt_no_done", 64'(done_total), 64'd0);

        do_op(OP_MULT, 32'hFFFFFFFD, 32'd7, ns, nd);
        check("mult_stall", 64'(ns), 64'd5);
        check("mult_done", 64'(nd), 64'd1);
        check("mult_hi", {32'd0, hi_o}, 64'hFFFFFFFF);
        check("mult_lo", {32'd0, lo_o}, 64'hFFFFFFEB);

        d0 = done_total;
        do_op(OP_MULTU, 32'hFFFFFFFD, 32'd7, ns, nd);
        repeat (3) @(negedge clk);
        #1;
        check("multu_stall", 64'(ns), 64'd5);
        check("multu_hi", {32'd0, hi_o}, 64'h00000006);
        check("multu_lo", {32'd0, lo_o}, 64'hFFFFFFEB);
        check("hold_through_done_one_op", 64'(done_total - d0), 64'd1);
        check("hold_idle_after", {63'd0, busy_o}, 64'd0);

        do_op(OP_DIVU, 32'd100, 32'd7, ns, nd);
        check("divu_stall", 64'(ns), 64'd34);
        check("divu_done", 64'(nd), 64'd1);
        check("divu_lo", {32'd0, lo_o}, 64'd14);
        check("divu_hi", {32'd0, hi_o}, 64'd2);

        do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, ns, nd);
        check("div_neg_stall", 64'(ns), 64'd34);
        check("div_neg_lo", {32'd0, lo_o}, 64'hFFFFFFFD);
        check("div_neg_hi", {32'd0, hi_o}, 64'hFFFFFFFF);

        do_op(OP_DIV, 32'd7, 32'hFFFFFFFE, ns, nd);
        check("div_negb_lo", {32'd0, lo_o}, 64'hFFFFFFFD);
        check("div_negb_hi", {32'd0, hi_o}, 64'd1);

        do_op(OP_DIV, 32'd5, 32'd0, ns, nd);
        check("div0_stall", 64'(ns), 64'd2);
        check("div0_done", 64'(nd), 64'd1);
        check("div0_hi", {32'd0, hi_o}, 64'd0);
        check("div0_lo", {32'd0, lo_o}, 64'd0);

        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, ns, nd);
        check("div_wrap_lo", {32'd0, lo_o}, 64'h80000000);
        check("div_wrap_hi", {32'd0, hi_o}, 64'd0);

        // Flush on the 10th DIV_RUN cycle.
        do_op(OP_MTHI, 32'h11, 32'd0, ns, nd);
        do_op(OP_MTLO, 32'h22, 32'd0, ns, nd);
        d0 = done_total;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_op_i    = OP_DIVU;
        req_a_i     = 32'd1000;
        req_b_i     = 32'd3;
        #1;
        check("flush_accept_stall", {63'd0, stall_o}, 64'd1);
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        #1;
        check("flush_stall_low", {63'd0, stall_o}, 64'd0);
        check("flush_busy_before", {63'd0, busy_o}, 64'd1);
        @(negedge clk);
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        req_op_i    = 3'b000;
        #1;
        check("flush_idle", {63'd0, busy_o}, 64'd0);
        repeat (3) @(negedge clk);
        #1;
        check("flush_hi", {32'd0, hi_o}, 64'h11);
        check("flush_lo", {32'd0, lo_o}, 64'h22);
        check("flush_no_done", 64'(done_total - d0), 64'd0);

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        req_valid_i = 1'b1;
        req_op_i    = OP_MULT;
        flush_i     = 1'b1;
        #1;
        check("idle_flush_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        req_valid_i = 1'b0;
        req_op_i    = 3'b000;
        flush_i     = 1'b0;
        #1;
        check("idle_flush_busy", {63'd0, busy_o}, 64'd0);

        do_op(OP_DIVU, 32'd3, 32'd10, ns, nd);
        check("early_stall", 64'(ns), 64'(exp_early_stall));
        check("early_lo", {32'd0, lo_o}, 64'd0);
        check("early_hi", {32'd0, hi_o}, 64'd3);

        // Reset mid-divide discards everything.
        @(negedge clk);
        req_valid_i = 1'b1;
        req_op_i    = OP_DIVU;
        req_a_i     = 32'd50;
        req_b_i     = 32'd3;
        repeat (3) @(negedge clk);
        req_valid_i = 1'b0;
        req_op_i    = 3'b000;
        rstn        = 1'b0;
        #1;
        check("midreset_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        #1;
        check("midreset_busy", {63'd0, busy_o}, 64'd0);
        check("midreset_hi", {32'd0, hi_o}, 64'd0);
        check("midreset_lo", {32'd0, lo_o}, 64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
